// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads the instruction memory and queues words for decode.
// Optional macro MISALIGN_TRAP_EN turns misaligned redirect targets into a sticky fault.
module instruction_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_address,
    input  logic [31:0] im_instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc_plus4,
    output logic        fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   pc_reg, pc_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pcp4_q  [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic [31:0] pc_plus4;
    logic        pop;
    logic        push;
    logic        redirect_eff;
    logic [31:0] target_eff;
    logic        push_allow;

`ifdef MISALIGN_TRAP_EN
    logic fault_reg, fault_next;

    // Once trapped, the sequencer is dead until reset: no redirects, no fetches.
    assign redirect_eff = redirect && !fault_reg;
    assign target_eff   = redirect_target;
    assign push_allow   = !fault_reg;
    assign fault_next   = fault_reg | (redirect_eff && (redirect_target[1:0] != 2'b00));
    assign fault        = fault_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_reg <= 1'b0;
        else        fault_reg <= fault_next;
    end
`else
    assign redirect_eff = redirect;
    assign target_eff   = redirect_target & 32'hFFFF_FFFC;
    assign push_allow   = 1'b1;
    assign fault        = 1'b0;
`endif

    assign im_address = pc_reg;
    assign pc_plus4   = pc_reg + 32'd4;
    assign out_valid  = (count_reg != '0);
    assign pop        = out_valid && out_ready;
    // A full FIFO may still accept the read when the head leaves in the same cycle.
    assign push       = !redirect_eff && push_allow &&
                        ((count_reg != FULL_COUNT) || pop);

    assign out_instruction = instr_q[rd_ptr_reg];
    assign out_pc_plus4    = pcp4_q[rd_ptr_reg];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
    end

    always_comb begin
        pc_next     = pc_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (redirect_eff) begin
            pc_next     = target_eff;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                pc_next     = pc_plus4;
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            pc_reg     <= pc_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entries are cleared on reset so the outputs read zero before the first fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pcp4_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    instr_q[i] <= im_instruction;
                    pcp4_q[i]  <= pc_plus4;
                end
            end
        end
    end

endmodule
